// File: rtl/qtree_mm_loader.sv
// Quadtree management loader: packs D_CNT-1 keys per node and writes the node word to one tree stage.
// Optional address bounds checking is enabled by defining QTREE_LOADER_BOUNDS_CHECK_EN.
module qtree_mm_loader #(
    parameter int STAGES_CNT  = 5,
    parameter int KEY_WIDTH   = 16,
    parameter int D_CNT       = 4,
    parameter int NODE_WIDTH  = (D_CNT - 1) * KEY_WIDTH,
    parameter int ADDR_WIDTH  = (STAGES_CNT - 1) * 2,
    parameter int STAGE_WIDTH = (STAGES_CNT > 2) ? $clog2(STAGES_CNT) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   cmd_valid_i,
    output logic                   cmd_ready_o,
    input  logic [STAGE_WIDTH-1:0] cmd_stage_i,
    input  logic [ADDR_WIDTH-1:0]  cmd_addr_i,
    input  logic [KEY_WIDTH-1:0]   cmd_key_i,
    input  logic                   cmd_last_i,
    output logic [NODE_WIDTH-1:0]  mm_ram_data_o,
    output logic [ADDR_WIDTH-1:0]  mm_ram_addr_o,
    output logic [STAGES_CNT-1:0]  mm_ram_write_o,
    output logic                   node_done_o,
    output logic                   busy_o,
    output logic                   err_o,
    input  logic                   err_clr_i
);
    localparam int SLOTS = D_CNT - 1;
    localparam int CNT_W = $clog2(D_CNT) + 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_WRITE   = 2'd2,
        ST_DROP    = 2'd3
    } state_t;

    function automatic logic [ADDR_WIDTH-1:0] low_mask(input int bits);
        logic [ADDR_WIDTH-1:0] m;
        for (int i = 0; i < ADDR_WIDTH; i++) begin
            m[i] = (i < bits);
        end
        return m;
    endfunction

    // Stage g spans 2g address bits; stage 0 is special-cased by the caller.
    function automatic int stage_bits(input logic [STAGE_WIDTH-1:0] stage, input int stage0_bits);
        return (stage == {STAGE_WIDTH{1'b0}}) ? stage0_bits : 2 * int'(stage);
    endfunction

    state_t                  state_r, state_nxt_s;
    logic [CNT_W-1:0]        count_r, count_nxt_s, slot_s;
    logic [NODE_WIDTH-1:0]   buf_r, buf_nxt_s, word_s;
    logic [STAGE_WIDTH-1:0]  stage_r, stage_nxt_s, cur_stage_s;
    logic [ADDR_WIDTH-1:0]   addr_r, addr_nxt_s, cur_addr_s, wr_addr_s;
    logic                    accept_s, finish_s, ovf_s, stage_ok_s, addr_ok_s, issue_s, err_set_s;
    logic [STAGES_CNT-1:0]   strobe_s;

    logic                    ready_r, busy_r, done_r, err_r;
    logic [STAGES_CNT-1:0]   write_r;
    logic [NODE_WIDTH-1:0]   data_r;
    logic [ADDR_WIDTH-1:0]   mm_addr_r;

    assign accept_s = cmd_valid_i && ready_r;

    // Current node context and the node word with the incoming key merged into its slot.
    always_comb begin
        if (state_r == ST_IDLE) begin
            cur_stage_s = cmd_stage_i;
            cur_addr_s  = cmd_addr_i;
            slot_s      = {CNT_W{1'b0}};
            word_s      = {NODE_WIDTH{1'b1}};
        end else begin
            cur_stage_s = stage_r;
            cur_addr_s  = addr_r;
            slot_s      = count_r;
            word_s      = buf_r;
        end
        if (int'(slot_s) < SLOTS) begin
            word_s[int'(slot_s)*KEY_WIDTH +: KEY_WIDTH] = cmd_key_i;
        end else begin
            word_s = word_s;
        end
    end

    // Next-state logic for node collection.
    always_comb begin
        state_nxt_s = state_r;
        count_nxt_s = count_r;
        buf_nxt_s   = buf_r;
        stage_nxt_s = stage_r;
        addr_nxt_s  = addr_r;
        finish_s    = 1'b0;
        ovf_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    stage_nxt_s = cmd_stage_i;
                    addr_nxt_s  = cmd_addr_i;
                    buf_nxt_s   = word_s;
                    count_nxt_s = CNT_W'(1);
                    finish_s    = cmd_last_i;
                    state_nxt_s = cmd_last_i ? ST_WRITE : ST_COLLECT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_COLLECT: begin
                if (accept_s && (int'(count_r) >= SLOTS)) begin
                    ovf_s       = 1'b1;
                    count_nxt_s = {CNT_W{1'b0}};
                    state_nxt_s = cmd_last_i ? ST_IDLE : ST_DROP;
                end else if (accept_s) begin
                    buf_nxt_s   = word_s;
                    count_nxt_s = count_r + CNT_W'(1);
                    finish_s    = cmd_last_i;
                    state_nxt_s = cmd_last_i ? ST_WRITE : ST_COLLECT;
                end else begin
                    state_nxt_s = ST_COLLECT;
                end
            end
            ST_WRITE: begin
                count_nxt_s = {CNT_W{1'b0}};
                state_nxt_s = ST_IDLE;
            end
            ST_DROP: begin
                if (accept_s && cmd_last_i) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DROP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Node acceptance checks and the write strobe for a completed node.
    always_comb begin
        stage_ok_s = int'(cur_stage_s) < STAGES_CNT;
`ifdef QTREE_LOADER_BOUNDS_CHECK_EN
        addr_ok_s  = (cur_addr_s & ~low_mask(stage_bits(cur_stage_s, 0))) == {ADDR_WIDTH{1'b0}};
        wr_addr_s  = cur_addr_s;
`else
        addr_ok_s  = 1'b1;
        wr_addr_s  = cur_addr_s & low_mask(stage_bits(cur_stage_s, 1));
`endif
        issue_s    = finish_s && stage_ok_s && addr_ok_s;
        err_set_s  = ovf_s || (finish_s && !issue_s);
        if (issue_s) begin
            strobe_s = {{(STAGES_CNT-1){1'b0}}, 1'b1} << cur_stage_s;
        end else begin
            strobe_s = {STAGES_CNT{1'b0}};
        end
    end

    // FSM state and node context registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
            count_r <= {CNT_W{1'b0}};
            buf_r   <= {NODE_WIDTH{1'b0}};
            stage_r <= {STAGE_WIDTH{1'b0}};
            addr_r  <= {ADDR_WIDTH{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            count_r <= count_nxt_s;
            buf_r   <= buf_nxt_s;
            stage_r <= stage_nxt_s;
            addr_r  <= addr_nxt_s;
        end
    end

    // Registered outputs; data/address only move when a write is issued.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ready_r   <= 1'b1;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
            write_r   <= {STAGES_CNT{1'b0}};
            data_r    <= {NODE_WIDTH{1'b0}};
            mm_addr_r <= {ADDR_WIDTH{1'b0}};
        end else begin
            ready_r <= (state_nxt_s != ST_WRITE);
            busy_r  <= (state_nxt_s != ST_IDLE);
            done_r  <= issue_s;
            write_r <= strobe_s;
            if (issue_s) begin
                data_r    <= word_s;
                mm_addr_r <= wr_addr_s;
            end else begin
                data_r    <= data_r;
                mm_addr_r <= mm_addr_r;
            end
            if (err_set_s) begin
                err_r <= 1'b1;
            end else if (err_clr_i) begin
                err_r <= 1'b0;
            end else begin
                err_r <= err_r;
            end
        end
    end

    assign cmd_ready_o    = ready_r;
    assign busy_o         = busy_r;
    assign node_done_o    = done_r;
    assign err_o          = err_r;
    assign mm_ram_write_o = write_r;
    assign mm_ram_data_o  = data_r;
    assign mm_ram_addr_o  = mm_addr_r;

endmodule

// File: tb/tb_qtree_mm_loader.sv
// Self-checking bench for qtree_mm_loader: directed scenarios plus randomized nodes against a node-level model.
module tb_qtree_mm_loader;
    localparam int NS = 5;
    localparam int KW = 16;
    localparam int NW = 48;
    localparam int AW = 8;
    localparam int SW = 3;

    logic          clk = 1'b0;
    logic          rst_i, cmd_valid_i, cmd_last_i, err_clr_i;
    logic          cmd_ready_o, node_done_o, busy_o, err_o;
    logic [SW-1:0] cmd_stage_i;
    logic [AW-1:0] cmd_addr_i, mm_ram_addr_o;
    logic [KW-1:0] cmd_key_i;
    logic [NW-1:0] mm_ram_data_o;
    logic [NS-1:0] mm_ram_write_o;

    int checks = 0;
    int failures = 0;

    logic [KW-1:0] node_keys[8];
    int            n_keys;
    logic [SW-1:0] n_stage;
    logic [AW-1:0] n_addr;
    bit            gaps_en, clr_on_last, exp_err;
    logic [NW-1:0] last_data;
    logic [AW-1:0] last_addr;

    qtree_mm_loader dut (
        .clk_i(clk), .rst_i(rst_i), .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_stage_i(cmd_stage_i), .cmd_addr_i(cmd_addr_i), .cmd_key_i(cmd_key_i),
        .cmd_last_i(cmd_last_i), .mm_ram_data_o(mm_ram_data_o), .mm_ram_addr_o(mm_ram_addr_o),
        .mm_ram_write_o(mm_ram_write_o), .node_done_o(node_done_o), .busy_o(busy_o),
        .err_o(err_o), .err_clr_i(err_clr_i)
    );

    always #5 clk = ~clk;

    // Node-level reference: overflow, stage/address legality, padded data word, effective address.
    function automatic void model_node(output bit ovf, output bit wr,
                                       output logic [NW-1:0] data, output logic [AW-1:0] addr);
        int depth;
        bit ok;
        ovf = n_keys > 3;
`ifdef QTREE_LOADER_BOUNDS_CHECK_EN
        depth = (n_stage == 3'd0) ? 1 : 4 ** int'(n_stage);
        ok    = int'(n_addr) < depth;
        addr  = n_addr;
`else
        depth = (n_stage == 3'd0) ? 2 : 4 ** int'(n_stage);
        ok    = 1'b1;
        addr  = AW'(int'(n_addr) % depth);
`endif
        wr = !ovf && (int'(n_stage) < NS) && ok;
        for (int i = 0; i < 3; i++) begin
            data[i*KW +: KW] = (i < n_keys) ? node_keys[i] : 16'hFFFF;
        end
    endfunction

    task automatic drive_node();
        int idx = 0;
        int guard = 0;
        bit acc;
        while (idx < n_keys && guard < 100) begin
            if (gaps_en && $urandom_range(0, 3) == 0) begin
                cmd_valid_i = 1'b0;
            end else begin
                cmd_valid_i = 1'b1;
                cmd_key_i   = node_keys[idx];
                cmd_last_i  = (idx == n_keys - 1);
                cmd_stage_i = (idx == 0) ? n_stage : 3'($urandom_range(0, 7));
                cmd_addr_i  = (idx == 0) ? n_addr : 8'($urandom);
                err_clr_i   = clr_on_last && (idx == n_keys - 1);
            end
            acc = cmd_valid_i && cmd_ready_o;
            @(posedge clk);
            @(negedge clk);
            err_clr_i = 1'b0;
            if (acc) begin
                idx++;
                if (idx < n_keys) begin
                    checks++;
                    if (mm_ram_write_o !== 5'b00000) begin
                        failures++;
                        $display("FAIL strobe_mid_node got=%b want=00000", mm_ram_write_o);
                    end
                end
            end
            guard++;
        end
        if (guard >= 100) begin
            checks++;
            failures++;
            $display("FAIL node_timeout accepted=%0d want=%0d", idx, n_keys);
        end
    endtask

    task automatic check_node(input string name);
        bit ovf, wr;
        logic [NW-1:0] ed;
        logic [AW-1:0] ea;
        logic [NS-1:0] es;
        model_node(ovf, wr, ed, ea);
        es = wr ? (5'b00001 << n_stage) : 5'b00000;
        if (!wr) begin
            ed = last_data;
            ea = last_addr;
            exp_err = 1'b1;
        end
        checks++;
        if (mm_ram_write_o !== es) begin failures++; $display("FAIL %s strobe got=%b want=%b", name, mm_ram_write_o, es); end
        checks++;
        if (node_done_o !== wr) begin failures++; $display("FAIL %s node_done got=%b want=%b", name, node_done_o, wr); end
        checks++;
        if (mm_ram_data_o !== ed) begin failures++; $display("FAIL %s data got=%h want=%h", name, mm_ram_data_o, ed); end
        checks++;
        if (mm_ram_addr_o !== ea) begin failures++; $display("FAIL %s addr got=%h want=%h", name, mm_ram_addr_o, ea); end
        checks++;
        if (err_o !== exp_err) begin failures++; $display("FAIL %s err got=%b want=%b", name, err_o, exp_err); end
        checks++;
        if (cmd_ready_o !== ovf || busy_o !== !ovf) begin
            failures++;
            $display("FAIL %s ready_busy got=%b%b want=%b%b", name, cmd_ready_o, busy_o, ovf, !ovf);
        end
        if (wr) begin
            last_data = ed;
            last_addr = ea;
        end
    endtask

    task automatic idle_gap(input string name);
        cmd_valid_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (mm_ram_write_o !== 5'b00000 || node_done_o !== 1'b0) begin
            failures++;
            $display("FAIL %s post_write strobe=%b done=%b want 00000/0", name, mm_ram_write_o, node_done_o);
        end
        checks++;
        if (busy_o !== 1'b0 || cmd_ready_o !== 1'b1 || mm_ram_data_o !== last_data) begin
            failures++;
            $display("FAIL %s idle busy=%b ready=%b data=%h want 0/1/%h", name, busy_o, cmd_ready_o, mm_ram_data_o, last_data);
        end
    endtask

    task automatic clear_err();
        err_clr_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        err_clr_i = 1'b0;
        exp_err = 1'b0;
        checks++;
        if (err_o !== 1'b0) begin failures++; $display("FAIL err_clear got=%b want=0", err_o); end
    endtask

    task automatic set_node(input logic [SW-1:0] s, input logic [AW-1:0] a, input int n);
        n_stage = s;
        n_addr  = a;
        n_keys  = n;
    endtask

    task automatic test_reset();
        checks++;
        if (cmd_ready_o !== 1'b1 || busy_o !== 1'b0 || err_o !== 1'b0 || node_done_o !== 1'b0 ||
            mm_ram_write_o !== 5'b00000 || mm_ram_data_o !== 48'h0 || mm_ram_addr_o !== 8'h0) begin
            failures++;
            $display("FAIL reset_values ready=%b busy=%b err=%b done=%b wr=%b data=%h addr=%h want 1/0/0/0/00000/0/0",
                     cmd_ready_o, busy_o, err_o, node_done_o, mm_ram_write_o, mm_ram_data_o, mm_ram_addr_o);
        end
    endtask

    task automatic test_full_node();
        set_node(3'd2, 8'd5, 3);
        node_keys[0] = 16'h0010; node_keys[1] = 16'h0020; node_keys[2] = 16'h0030;
        drive_node();
        checks++;
        if (mm_ram_data_o !== 48'h0030_0020_0010 || mm_ram_write_o !== 5'b00100 || mm_ram_addr_o !== 8'd5) begin
            failures++;
            $display("FAIL full_node_const data=%h wr=%b addr=%0d want 003000200010/00100/5", mm_ram_data_o, mm_ram_write_o, mm_ram_addr_o);
        end
        check_node("full_node");
        idle_gap("full_node");
    endtask

    task automatic test_short_node();
        set_node(3'd0, 8'd0, 1);
        node_keys[0] = 16'h1234;
        drive_node();
        checks++;
        if (mm_ram_data_o !== 48'hFFFF_FFFF_1234 || mm_ram_write_o !== 5'b00001) begin
            failures++;
            $display("FAIL short_node_const data=%h wr=%b want ffffffff1234/00001", mm_ram_data_o, mm_ram_write_o);
        end
        check_node("short_node");
        idle_gap("short_node");
    endtask

    task automatic test_overflow();
        set_node(3'd1, 8'd1, 4);
        for (int i = 0; i < 8; i++) node_keys[i] = 16'(16'h0100 + i);
        drive_node();
        check_node("overflow_last");
        idle_gap("overflow_last");
        set_node(3'd3, 8'd9, 6);
        drive_node();
        check_node("overflow_drop");
        idle_gap("overflow_drop");
        set_node(3'd1, 8'd2, 2);
        drive_node();
        check_node("after_overflow");
        idle_gap("after_overflow");
        clear_err();
    endtask

    task automatic test_bad_stage();
        set_node(3'd6, 8'd1, 3);
        drive_node();
        check_node("bad_stage");
        idle_gap("bad_stage");
        clear_err();
        clr_on_last = 1'b1;
        set_node(3'd7, 8'd0, 2);
        drive_node();
        clr_on_last = 1'b0;
        check_node("set_beats_clear");
        idle_gap("set_beats_clear");
        clear_err();
    endtask

    task automatic test_bounds();
        set_node(3'd1, 8'd4, 1);
        node_keys[0] = 16'hBEEF;
        drive_node();
        checks++;
`ifdef QTREE_LOADER_BOUNDS_CHECK_EN
        if (mm_ram_write_o !== 5'b00000 || err_o !== 1'b1) begin
            failures++;
            $display("FAIL bounds_const wr=%b err=%b want 00000/1", mm_ram_write_o, err_o);
        end
`else
        if (mm_ram_write_o !== 5'b00010 || mm_ram_addr_o !== 8'd0) begin
            failures++;
            $display("FAIL bounds_const wr=%b addr=%0d want 00010/0", mm_ram_write_o, mm_ram_addr_o);
        end
`endif
        check_node("bounds");
        idle_gap("bounds");
        clear_err();
    endtask

    task automatic test_reset_mid_node();
        cmd_valid_i = 1'b1; cmd_last_i = 1'b0; cmd_stage_i = 3'd2; cmd_addr_i = 8'd3;
        cmd_key_i = 16'hAAAA;
        @(posedge clk); @(negedge clk);
        cmd_key_i = 16'hBBBB;
        @(posedge clk); @(negedge clk);
        cmd_valid_i = 1'b0;
        rst_i = 1'b1;
        @(posedge clk); @(negedge clk);
        test_reset();
        rst_i = 1'b0;
        exp_err = 1'b0;
        last_data = 48'h0;
        last_addr = 8'h0;
        set_node(3'd3, 8'd7, 3);
        node_keys[0] = 16'h0A0A; node_keys[1] = 16'h0B0B; node_keys[2] = 16'h0C0C;
        drive_node();
        check_node("after_reset");
        idle_gap("after_reset");
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 4; n++) begin
            set_node(3'(n), 8'(n), 1 + (n % 3));
            for (int i = 0; i < 3; i++) node_keys[i] = 16'($urandom);
            drive_node();
            check_node("back_to_back");
        end
        idle_gap("back_to_back");
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            n_stage = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            n_addr  = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 3)) : 8'($urandom);
            n_keys  = ($urandom_range(0, 5) == 0) ? $urandom_range(4, 6) : $urandom_range(1, 3);
            for (int i = 0; i < 8; i++) node_keys[i] = 16'($urandom);
            gaps_en = $urandom_range(0, 1) == 1;
            drive_node();
            check_node("random");
            if ($urandom_range(0, 2) == 0) idle_gap("random");
            if (err_o && $urandom_range(0, 3) == 0) begin
                if (!cmd_ready_o) idle_gap("random_pre_clear");
                clear_err();
            end
        end
        gaps_en = 1'b0;
        idle_gap("random_end");
    endtask

    initial begin
        rst_i = 1'b1; cmd_valid_i = 1'b0; cmd_last_i = 1'b0; err_clr_i = 1'b0;
        cmd_stage_i = 3'd0; cmd_addr_i = 8'd0; cmd_key_i = 16'd0;
        gaps_en = 1'b0; clr_on_last = 1'b0; exp_err = 1'b0;
        last_data = 48'h0; last_addr = 8'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        test_reset();
        rst_i = 1'b0;
        @(negedge clk);
        test_full_node();
        test_short_node();
        test_overflow();
        test_bad_stage();
        test_bounds();
        test_reset_mid_node();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
